// File: rtl/l2_ddr_refill_ctrl.sv
// DDR-to-L2 refill controller: fetches a run of 128-bit lines in bursts and writes them into L2.
// Optional watchdog in DATA and the o_timeout port are enabled with `define L2_REFILL_TIMEOUT_EN.

// state      | meaning
// S_IDLE     | waiting for i_start
// S_WAIT_SPC | waiting until L2 has room for the next burst
// S_REQ      | DDR read request held until acknowledged
// S_DATA     | accepting beats and writing them into L2
// S_DONE     | one-cycle completion pulse
module l2_ddr_refill_ctrl #(
   parameter int BURST_LINES    = 8,
   parameter int L2_DEPTH_WORDS = 4095,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic          clk_166M66,
   input  logic          mcu_sys_rst_n,
   input  logic          i_start,
   input  logic [27:0]   i_base_addr,
   input  logic [15:0]   i_line_count,
   output logic          o_busy,
   output logic          o_done,
   input  logic [11:0]   i_l2_unread_size,
   input  logic          i_l1ddr_rw_confilicts,
   output logic          o_ddr_operate_enable,
   output logic          o_ddr_rw,
   output logic [127:0]  o_ddr_data,
   output logic          o_rd_req,
   output logic [27:0]   o_rd_addr,
   output logic [4:0]    o_rd_len,
   input  logic          i_rd_ack,
   input  logic          i_rd_valid,
   input  logic [127:0]  i_rd_data,
   output logic          o_rd_ready
`ifdef L2_REFILL_TIMEOUT_EN
   ,
   output logic          o_timeout
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_SPC,
      S_REQ,
      S_DATA,
      S_DONE
   } state_t;

   localparam logic [4:0]  BURST_L   = 5'(BURST_LINES);
   localparam logic [12:0] DEPTH_L   = 13'(L2_DEPTH_WORDS);

   if (BURST_LINES < 1 || BURST_LINES > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("l2_ddr_refill_ctrl: illegal parameter value");
   end

   state_t         r_state;
   state_t         w_state_nxt;
   logic [27:0]    r_addr;
   logic [15:0]    r_rem;
   logic [4:0]     r_beat;
   logic           r_hold_v;
   logic [127:0]   r_hold_d;
   logic [4:0]     w_len;
   logic [12:0]    w_space_sum;
   logic           w_space_ok;
   logic           w_wr_fire;
   logic           w_accept;
   logic           w_start_ok;
   logic           w_ack_ok;
   logic           w_tmo;

   assign w_start_ok  = (r_state == S_IDLE) && i_start;
   assign w_ack_ok    = (r_state == S_REQ) && i_rd_ack;
   assign w_len       = (r_rem >= 16'(BURST_LINES)) ? BURST_L : r_rem[4:0];
   // 13-bit sum so a nearly full L2 can never wrap into an apparent free space
   assign w_space_sum = {1'b0, i_l2_unread_size} + {5'b0, w_len, 3'b000};
   assign w_space_ok  = (w_space_sum <= DEPTH_L);

   assign w_wr_fire   = r_hold_v && !i_l1ddr_rw_confilicts;
   assign o_rd_ready  = (r_state == S_DATA) && (r_beat != 5'd0) && (!r_hold_v || w_wr_fire);
   assign w_accept    = i_rd_valid && o_rd_ready;

   assign o_ddr_operate_enable = w_wr_fire;
   assign o_ddr_rw             = w_wr_fire;
   assign o_ddr_data           = w_wr_fire ? r_hold_d : 128'd0;
   assign o_rd_addr            = (r_state == S_REQ) ? r_addr : 28'd0;
   assign o_rd_len             = (r_state == S_REQ) ? w_len : 5'd0;

   always_ff @(posedge clk_166M66) begin
      if (!mcu_sys_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      o_busy      = 1'b0;
      o_done      = 1'b0;
      o_rd_req    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_nxt = (i_line_count == 16'd0) ? S_DONE : S_WAIT_SPC;
            end
         end
         S_WAIT_SPC: begin
            o_busy = 1'b1;
            if (w_space_ok) begin
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            o_busy   = 1'b1;
            o_rd_req = 1'b1;
            if (i_rd_ack) begin
               w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            o_busy = 1'b1;
            if (w_tmo) begin
               w_state_nxt = S_DONE;
            end else if ((r_beat == 5'd0) && !r_hold_v) begin
               w_state_nxt = (r_rem == 16'd0) ? S_DONE : S_WAIT_SPC;
            end
         end
         S_DONE: begin
            o_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_166M66) begin
      if (!mcu_sys_rst_n) begin
         r_addr   <= 28'd0;
         r_rem    <= 16'd0;
         r_beat   <= 5'd0;
         r_hold_v <= 1'b0;
         r_hold_d <= 128'd0;
      end else begin
         if (w_start_ok) begin
            r_addr <= i_base_addr;
            r_rem  <= i_line_count;
         end
         if (w_ack_ok) begin
            r_beat <= w_len;
            r_addr <= r_addr + 28'(w_len);
            r_rem  <= r_rem - 16'(w_len);
         end
         // a same-cycle accept and write simply reloads the holding register
         if (w_accept) begin
            r_beat   <= r_beat - 5'd1;
            r_hold_v <= 1'b1;
            r_hold_d <= i_rd_data;
         end else if (w_wr_fire) begin
            r_hold_v <= 1'b0;
         end
         if (w_tmo) begin
            r_hold_v <= 1'b0;
            r_beat   <= 5'd0;
         end
      end
   end

`ifdef L2_REFILL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] r_tmo_cnt;
   logic          r_timeout;

   // down-counter: expires after TIMEOUT_CYCLES consecutive DATA cycles without a beat
   assign w_tmo     = (r_state == S_DATA) && (r_tmo_cnt == '0) && !w_accept;
   assign o_timeout = r_timeout;

   always_ff @(posedge clk_166M66) begin
      if (!mcu_sys_rst_n) begin
         r_tmo_cnt <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (w_ack_ok || w_accept) begin
            r_tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
         end else if ((r_state == S_DATA) && (r_tmo_cnt != '0)) begin
            r_tmo_cnt <= r_tmo_cnt - 1'b1;
         end
         if (w_start_ok) begin
            r_timeout <= 1'b0;
         end else if (w_tmo) begin
            r_timeout <= 1'b1;
         end
      end
   end
`else
   assign w_tmo = 1'b0;
`endif

endmodule
